// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first set request starting at ptr, wrapping mod 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    idx  = 2'd0;
    any  = 1'b0;
    cand = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux; bounded bursts, zero-bubble handover.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, sel_nxt, rel_ptr;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    gnt_nxt;
  logic [DW-1:0] dout_nxt, mux_data;
  logic          dv_nxt, release_now;
  logic [1:0]    idle_idx, rel_idx;
  logic          idle_any, rel_any;

  assign rel_ptr = ptr_inc(sel);
  assign cnt_inc = cnt + CW'(1);

  rr_pick4 u_pick_idle (.req(req), .ptr(ptr),     .idx(idle_idx), .any(idle_any));
  rr_pick4 u_pick_rel  (.req(req), .ptr(rel_ptr), .idx(rel_idx),  .any(rel_any));

  always_comb begin
    case (sel)
      2'd0:    mux_data = din0;
      2'd1:    mux_data = din1;
      2'd2:    mux_data = din2;
      default: mux_data = din3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 4'b0000;
      sel        <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ptr        <= 2'd0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      sel        <= sel_nxt;
      dout       <= dout_nxt;
      dout_valid <= dv_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // In GRANT the registered sel is the granted index k.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    dout_nxt    = dout;
    dv_nxt      = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (idle_any) begin
          gnt_nxt   = 4'b0001 << idle_idx;
          sel_nxt   = idle_idx;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (req[sel]) begin
          dout_nxt = mux_data;
          dv_nxt   = 1'b1;
          cnt_nxt  = cnt_inc;
          if (cnt_inc == CW'(MAX_BURST)) release_now = 1'b1;
        end else begin
          release_now = 1'b1;
        end
        if (release_now) begin
          ptr_nxt = rel_ptr;
          cnt_nxt = '0;
          if (rel_any) begin
            gnt_nxt = 4'b0001 << rel_idx;
            sel_nxt = rel_idx;
          end else begin
            gnt_nxt   = 4'b0000;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = |gnt;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: three arbiter instances (MAX_BURST 4, 2, 1) share one stimulus stream.
module tb_mux4_rr_arbiter;

  logic       clk, rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;

  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       dv_a, dv_b, dv_c;
  logic       busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.DW(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a));

  mux4_rr_arbiter #(.DW(8), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b));

  mux4_rr_arbiter #(.DW(8), .MAX_BURST(1)) dut_c (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt_c), .sel(sel_c), .dout(dout_c), .dout_valid(dv_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_b [9];
  logic [7:0] exp_c [9];

  initial begin
    exp_b = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h10};
    exp_c = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    rst  = 1'b1;
    req  = 4'b0000;
    din0 = 8'h10;
    din1 = 8'h11;
    din2 = 8'hA5;
    din3 = 8'h13;
    #3;
    chk("rst_gnt",  32'(gnt_a),  32'h0);
    chk("rst_sel",  32'(sel_a),  32'h0);
    chk("rst_dout", 32'(dout_a), 32'h0);
    chk("rst_dv",   32'(dv_a),   32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_gnt_c", 32'(gnt_c), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // single requester, burst of 4 then zero-bubble regrant
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt_a), 32'h4);
    chk("single_sel", 32'(sel_a), 32'h2);
    chk("single_dv0", 32'(dv_a),  32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_dv",   32'(dv_a),   32'h1);
      chk("single_dout", 32'(dout_a), 32'hA5);
      chk("single_hold", 32'(gnt_a),  32'h4);
    end
    req = 4'b0000;
    tick();
    chk("drop_dv",   32'(dv_a),   32'h0);
    chk("drop_gnt",  32'(gnt_a),  32'h0);
    chk("drop_busy", 32'(busy_a), 32'h0);

    // idle gap, dout holds
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt",  32'(gnt_a),  32'h0);
      chk("idle_dv",   32'(dv_a),   32'h0);
      chk("idle_dout", 32'(dout_a), 32'hA5);
    end

    // ptr=3 after serving 2: requester 3 wins over 0
    req = 4'b1001;
    tick();
    chk("wrap_gnt", 32'(gnt_a), 32'h8);
    chk("wrap_sel", 32'(sel_a), 32'h3);
    tick();
    chk("wrap_dout", 32'(dout_a), 32'h13);
    chk("wrap_dv",   32'(dv_a),   32'h1);
    req = 4'b0000;
    tick();
    chk("wrap_idle", 32'(gnt_a), 32'h0);
    req = 4'b0010;
    tick();
    chk("gap_gnt", 32'(gnt_a), 32'h2);
    chk("gap_dv",  32'(dv_a),  32'h0);
    tick();
    chk("gap_dout", 32'(dout_a), 32'h11);
    chk("gap_dv1",  32'(dv_a),   32'h1);

    // asynchronous reset mid-grant
    din2 = 8'h12;
    req  = 4'b1111;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt",   32'(gnt_a),  32'h0);
    chk("arst_busy",  32'(busy_a), 32'h0);
    chk("arst_dv",    32'(dv_a),   32'h0);
    chk("arst_gnt_b", 32'(gnt_b),  32'h0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_gnt",   32'(gnt_a), 32'h1);
    chk("post_rst_sel",   32'(sel_a), 32'h0);
    chk("post_rst_gnt_b", 32'(gnt_b), 32'h1);

    // round robin with all four requesting
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_b_dout", 32'(dout_b), 32'(exp_b[i]));
      chk("rr_b_dv",   32'(dv_b),   32'h1);
      chk("rr_c_dout", 32'(dout_c), 32'(exp_c[i]));
      chk("rr_c_dv",   32'(dv_c),   32'h1);
      chk("rr_b_onehot", 32'(gnt_b), 32'(4'b0001 << sel_b));
    end

    // early drop: one word from 1, bubble, then requester 3
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b1010;
    tick();
    chk("early_gnt1", 32'(gnt_a), 32'h2);
    tick();
    chk("early_dout1", 32'(dout_a), 32'h11);
    chk("early_dv1",   32'(dv_a),   32'h1);
    req = 4'b1000;
    tick();
    chk("early_bubble", 32'(dv_a),   32'h0);
    chk("early_gnt3",   32'(gnt_a),  32'h8);
    chk("early_hold",   32'(dout_a), 32'h11);
    tick();
    chk("early_dout3", 32'(dout_a), 32'h13);
    chk("early_dv3",   32'(dv_a),   32'h1);
    chk("early_sel3",  32'(sel_a),  32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
